multicycle_controller_p: RTL

- Parametrised successor of the multicycle CPU control unit.
- Owns its state register; the state is no longer driven by the bench.
- Adds a memory-ready handshake with a timeout, stack push/pop, an illegal-opcode trap and a halt state.
- Drives the existing datapath load/tristate strobes (ldX, TX, fnSel, MemRead/MemWrite, IRWrite) from a Moore decode of the registered state.

---
 rtl/multicycle_controller_p.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller_p.sv
// Multicycle CPU control unit: owns its state register and drives the datapath
// strobes as a Moore decode of that state, with a memory-ready timeout, stack ops and traps.
module multicycle_controller_p #(
    parameter int IR_W = 16,
    parameter int OPC_W = 4,
    parameter int FN_W = 3,
    parameter int ST_W = 5,
    parameter logic [FN_W-1:0] FN_INC = 3'd6,
    parameter logic [FN_W-1:0] FN_DEC = 3'd7,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [IR_W-1:0] IR,
    input  logic            flag,
    input  logic            mem_ready,
    output logic [FN_W-1:0] fnSel,
    output logic            ldMAR,
    output logic            ldIR,
    output logic            ldPC,
    output logic            ldSP,
    output logic            ldMDR,
    output logic            ldReg,
    output logic            ldRegBank,
    output logic            TReg,
    output logic            TRegBank,
    output logic            TSP,
    output logic            TMAR,
    output logic            TPC,
    output logic            TMDR,
    output logic            TLabel,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic [ST_W-1:0] state,
    output logic            halted,
    output logic            illegal,
    output logic            mem_err
);

    localparam logic [ST_W-1:0] S_RST  = ST_W'(0);
    localparam logic [ST_W-1:0] S_F0   = ST_W'(1);
    localparam logic [ST_W-1:0] S_F1   = ST_W'(2);
    localparam logic [ST_W-1:0] S_F2   = ST_W'(3);
    localparam logic [ST_W-1:0] S_DEC  = ST_W'(4);
    localparam logic [ST_W-1:0] S_ALU  = ST_W'(5);
    localparam logic [ST_W-1:0] S_MA   = ST_W'(6);
    localparam logic [ST_W-1:0] S_MRD  = ST_W'(7);
    localparam logic [ST_W-1:0] S_MWD  = ST_W'(8);
    localparam logic [ST_W-1:0] S_WB   = ST_W'(9);
    localparam logic [ST_W-1:0] S_MWR  = ST_W'(10);
    localparam logic [ST_W-1:0] S_BR   = ST_W'(11);
    localparam logic [ST_W-1:0] S_PUSH = ST_W'(12);
    localparam logic [ST_W-1:0] S_POP  = ST_W'(13);
    localparam logic [ST_W-1:0] S_ILL  = ST_W'(14);
    localparam logic [ST_W-1:0] S_HALT = ST_W'(15);
    localparam logic [ST_W-1:0] S_MERR = ST_W'(16);

    localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ALU   = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_BRZ   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_PUSH  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_POP   = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(15);

    // Counter only needs to reach MEM_TIMEOUT-1: the timeout fires on the increment that would hit MEM_TIMEOUT.
    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [ST_W-1:0]  state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             is_store_reg, is_store_next;
    logic             mem_err_reg, mem_err_next;
    logic [OPC_W-1:0] opcode;
    logic             timeout;
    logic             unused_ir_mid;

    assign opcode        = IR[IR_W-1 -: OPC_W];
    assign unused_ir_mid = ^IR[IR_W-OPC_W-1:FN_W];
    assign timeout       = (wait_cnt_reg == CNT_LAST);
    assign state         = state_reg;
    assign mem_err       = mem_err_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= S_RST;
            wait_cnt_reg <= '0;
            is_store_reg <= 1'b0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            is_store_reg <= is_store_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        is_store_next = is_store_reg;
        mem_err_next  = mem_err_reg;
        case (state_reg)
            S_RST: state_next = S_F0;
            S_F0:  state_next = S_F1;
            S_F2:  state_next = S_DEC;
            // The three memory waits share one shape; completion is checked before timeout.
            S_F1, S_MRD, S_MWR: begin
                if (mem_ready) begin
                    state_next = (state_reg == S_F1)  ? S_F2 :
                                 (state_reg == S_MRD) ? S_WB : S_F0;
                end else if (timeout) begin
                    state_next = S_MERR;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            S_DEC: begin
                // LOAD/STORE choice is latched here so IR may change before MA resolves it.
                is_store_next = (opcode == OP_STORE);
                case (opcode)
                    OP_NOP:            state_next = S_F0;
                    OP_ALU:            state_next = S_ALU;
                    OP_LOAD, OP_STORE: state_next = S_MA;
                    OP_BRZ:            state_next = flag ? S_BR : S_F0;
                    OP_JMP:            state_next = S_BR;
                    OP_PUSH:           state_next = S_PUSH;
                    OP_POP:            state_next = S_POP;
                    OP_HALT:           state_next = S_HALT;
                    default:           state_next = S_ILL;
                endcase
            end
            S_ALU:  state_next = S_F0;
            S_MA:   state_next = is_store_reg ? S_MWD : S_MRD;
            S_MWD:  state_next = S_MWR;
            S_WB:   state_next = S_F0;
            S_BR:   state_next = S_F0;
            S_PUSH: state_next = S_MWD;
            S_POP:  state_next = S_MRD;
            S_ILL:  state_next = S_F0;
            S_HALT: state_next = S_HALT;
            S_MERR: state_next = S_MERR;
            default: state_next = S_RST;
        endcase
        if (state_next == S_MERR) mem_err_next = 1'b1;
    end

    always_comb begin
        fnSel = '0;
        ldMAR = 1'b0; ldIR = 1'b0; ldPC = 1'b0; ldSP = 1'b0;
        ldMDR = 1'b0; ldReg = 1'b0; ldRegBank = 1'b0;
        TReg = 1'b0; TRegBank = 1'b0; TSP = 1'b0; TMAR = 1'b0;
        TPC = 1'b0; TMDR = 1'b0; TLabel = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
        halted = 1'b0; illegal = 1'b0;
        case (state_reg)
            S_F0:   begin TPC = 1'b1; ldMAR = 1'b1; end
            S_F1:   begin MemRead = 1'b1; ldMDR = 1'b1; end
            S_F2:   begin TMDR = 1'b1; ldIR = 1'b1; IRWrite = 1'b1; end
            S_DEC:  begin TPC = 1'b1; ldPC = 1'b1; fnSel = FN_INC; end
            S_ALU:  begin TRegBank = 1'b1; ldReg = 1'b1; ldRegBank = 1'b1; fnSel = IR[FN_W-1:0]; end
            S_MA:   begin TLabel = 1'b1; ldMAR = 1'b1; end
            S_MRD:  begin MemRead = 1'b1; ldMDR = 1'b1; end
            S_MWD:  begin TRegBank = 1'b1; ldMDR = 1'b1; end
            S_MWR:  begin TMDR = 1'b1; MemWrite = 1'b1; end
            S_WB:   begin TMDR = 1'b1; ldRegBank = 1'b1; end
            S_BR:   begin TLabel = 1'b1; ldPC = 1'b1; end
            S_PUSH: begin TSP = 1'b1; ldMAR = 1'b1; ldSP = 1'b1; fnSel = FN_DEC; end
            S_POP:  begin TSP = 1'b1; ldMAR = 1'b1; ldSP = 1'b1; fnSel = FN_INC; end
            S_ILL:  illegal = 1'b1;
            S_HALT: halted = 1'b1;
            S_MERR: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
